// File: rtl/bt_tx_scheduler.sv
// bt_tx_scheduler: arbitrates two byte requesters into header+data packets for a serializer.
// Optional trailing XOR checksum byte enabled by defining BT_TX_CHECKSUM_EN.
module bt_tx_scheduler #(
  parameter logic [7:0] HDR_BASE = 8'hA0,
  parameter int         MAX_PKT  = 64
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic [1:0]      req_valid,
  input  logic [1:0][7:0] req_data,
  input  logic [1:0]      req_last,
  output logic [1:0]      req_ready,
  output logic [7:0]      ser_data,
  output logic            ser_send,
  input  logic            ser_done,
  output logic            grant_id,
  output logic            busy,
  output logic            pkt_done,
  output logic            pkt_trunc
);
`ifdef BT_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;
  logic [7:0] r_csum;
`else
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif
  state_t     r_state;
  logic       r_last_grant;
  logic       r_last;
  logic       r_done_q;
  logic [7:0] r_count;
  logic       w_rise;
  logic       w_win;
  logic       w_max;
  logic [7:0] w_hdr;
  // Completion only counts while a byte is actually outstanding.
  assign w_rise = ser_send & ser_done & ~r_done_q;
  assign w_win  = (&req_valid) ? ~r_last_grant : req_valid[1];
  assign w_max  = r_count == 8'(MAX_PKT);
  assign w_hdr  = HDR_BASE | {7'b0, w_win};
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      ser_send     <= 1'b0;
      ser_data     <= 8'h00;
      req_ready    <= 2'b00;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_trunc    <= 1'b0;
      r_last_grant <= 1'b1;
      r_last       <= 1'b0;
      r_count      <= 8'h00;
      r_done_q     <= 1'b0;
`ifdef BT_TX_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      r_done_q  <= ser_done;
      req_ready <= 2'b00;
      pkt_done  <= 1'b0;
      pkt_trunc <= 1'b0;
      case (r_state)
        IDLE: if (|req_valid) begin
          r_state      <= HDR;
          grant_id     <= w_win;
          r_last_grant <= w_win;
          ser_data     <= w_hdr;
          ser_send     <= 1'b1;
          busy         <= 1'b1;
`ifdef BT_TX_CHECKSUM_EN
          r_csum       <= w_hdr;
`endif
        end
        HDR: begin
          r_count <= 8'h00;
          if (w_rise) begin
            ser_send <= 1'b0;
            r_state  <= DATA;
          end
        end
        DATA: if (!ser_send) begin
          if (req_valid[grant_id]) begin
            ser_data            <= req_data[grant_id];
            ser_send            <= 1'b1;
            req_ready[grant_id] <= 1'b1;
            r_last              <= req_last[grant_id];
            r_count             <= r_count + 8'd1;
`ifdef BT_TX_CHECKSUM_EN
            r_csum              <= r_csum ^ req_data[grant_id];
`endif
          end
        end else if (w_rise) begin
          ser_send <= 1'b0;
          if (r_last || w_max) begin
            pkt_trunc <= ~r_last;
`ifdef BT_TX_CHECKSUM_EN
            r_state   <= CSUM;
`else
            r_state   <= IDLE;
            busy      <= 1'b0;
            pkt_done  <= 1'b1;
`endif
          end
        end
`ifdef BT_TX_CHECKSUM_EN
        CSUM: if (!ser_send) begin
          ser_data <= r_csum;
          ser_send <= 1'b1;
        end else if (w_rise) begin
          ser_send <= 1'b0;
          r_state  <= IDLE;
          busy     <= 1'b0;
          pkt_done <= 1'b1;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bt_tx_scheduler.sv
// tb_bt_tx_scheduler: directed bench for bt_tx_scheduler (MAX_PKT=2, serializer completes 10 cycles after send).
module tb_bt_tx_scheduler;
  logic            clk = 1'b0;
  logic            rst_in = 1'b0;
  logic [1:0]      req_valid;
  logic [1:0][7:0] req_data;
  logic [1:0]      req_last;
  logic [1:0]      req_ready;
  logic [7:0]      ser_data;
  logic            ser_send;
  logic            ser_done;
  logic            grant_id;
  logic            busy;
  logic            pkt_done;
  logic            pkt_trunc;
  int passes = 0, total = 0, n_done = 0, n_trunc = 0, n_rdy0 = 0, sd_cnt = 0;
  logic prev_send = 1'b0, stall = 1'b0;
  logic [8:0] q0[$], q1[$];
  logic [7:0] log_q[$], exp_q[$];
  bt_tx_scheduler #(.MAX_PKT(2)) dut (
    .clk(clk), .rst_in(rst_in), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .ser_data(ser_data), .ser_send(ser_send),
    .ser_done(ser_done), .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done),
    .pkt_trunc(pkt_trunc)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      ser_done <= 1'b0;
      sd_cnt   <= 0;
    end else if (!ser_send) begin
      ser_done <= 1'b0;
      sd_cnt   <= 0;
    end else if (!ser_done) begin
      if (sd_cnt == 9) ser_done <= 1'b1;
      sd_cnt <= sd_cnt + 1;
    end
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive();
    req_valid[0] = q0.size() > 0 && !stall;
    req_valid[1] = q1.size() > 0;
    {req_last[0], req_data[0]} = q0.size() > 0 ? q0[0] : 9'h0;
    {req_last[1], req_data[1]} = q1.size() > 0 ? q1[0] : 9'h0;
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (ser_send && !prev_send) log_q.push_back(ser_data);
      prev_send = ser_send;
      n_done  += int'(pkt_done);
      n_trunc += int'(pkt_trunc);
      n_rdy0  += int'(req_ready[0]);
      if (req_ready[0] && q0.size() > 0) void'(q0.pop_front());
      if (req_ready[1] && q1.size() > 0) void'(q1.pop_front());
      drive();
    end
  endtask
  task automatic add_cs(input logic [7:0] v);
`ifdef BT_TX_CHECKSUM_EN
    exp_q.push_back(v);
`endif
  endtask
  task automatic check_seq(input string tag);
    chk({tag, "_len"}, 8'(log_q.size()), 8'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
    log_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int d, t, r;
    logic bad, found;
    drive();
    cyc(2);
    chk("rst_send", {7'b0, ser_send}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_data", ser_data, 8'h00);
    chk("rst_grant", {7'b0, grant_id}, 8'h00);
    chk("rst_ready", {6'b0, req_ready}, 8'h00);
    chk("rst_done", {7'b0, pkt_done}, 8'h00);
    rst_in = 1'b1;
    // tie from reset: req0 first, then req1
    q0.push_back({1'b1, 8'h33});
    q1.push_back({1'b1, 8'h44});
    drive();
    cyc(120);
    exp_q = '{8'hA0, 8'h33}; add_cs(8'h93);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h44); add_cs(8'hE5);
    check_seq("tie1");
    chk("tie1_done", 8'(n_done), 8'd2);
    // next tie goes back to req0
    q0.push_back({1'b1, 8'h55});
    q1.push_back({1'b1, 8'h66});
    drive();
    cyc(120);
    exp_q = '{8'hA0, 8'h55}; add_cs(8'hF5);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h66); add_cs(8'hC7);
    check_seq("tie2");
    d = n_done; t = n_trunc;
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b1, 8'h22});
    drive();
    cyc(100);
    exp_q = '{8'hA0, 8'h11, 8'h22}; add_cs(8'h93);
    check_seq("basic");
    chk("basic_done", 8'(n_done - d), 8'd1);
    chk("basic_trunc", 8'(n_trunc - t), 8'd0);
    chk("basic_busy", {7'b0, busy}, 8'h00);
    q1.push_back({1'b0, 8'h0F});
    q1.push_back({1'b1, 8'hF0});
    drive();
    cyc(100);
    exp_q = '{8'hA1, 8'h0F, 8'hF0}; add_cs(8'h5E);
    check_seq("req1");
    chk("req1_grant", {7'b0, grant_id}, 8'h01);
    d = n_done; t = n_trunc;
    q0.push_back({1'b0, 8'h01});
    q0.push_back({1'b0, 8'h02});
    q0.push_back({1'b1, 8'h03});
    drive();
    cyc(160);
    exp_q = '{8'hA0, 8'h01, 8'h02}; add_cs(8'hA3);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h03); add_cs(8'hA3);
    check_seq("trunc");
    chk("trunc_cnt", 8'(n_trunc - t), 8'd1);
    chk("trunc_done", 8'(n_done - d), 8'd2);
    d = n_done;
    q0.push_back({1'b0, 8'h10});
    drive();
    cyc(60);
    r = n_rdy0;
    bad = 1'b0;
    repeat (50) begin
      cyc(1);
      if (ser_send !== 1'b0 || req_ready !== 2'b00) bad = 1'b1;
    end
    chk("stall_quiet", {7'b0, bad}, 8'h00);
    chk("stall_ready", 8'(n_rdy0 - r), 8'd0);
    chk("stall_busy", {7'b0, busy}, 8'h01);
    q0.push_back({1'b1, 8'h20});
    drive();
    cyc(60);
    exp_q = '{8'hA0, 8'h10, 8'h20}; add_cs(8'h90);
    check_seq("stall");
    chk("stall_done", 8'(n_done - d), 8'd1);
    q0.push_back({1'b0, 8'h77});
    q0.push_back({1'b1, 8'h88});
    drive();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1);
      found = ser_send && ser_data == 8'h77;
    end
    chk("rst_found", {7'b0, found}, 8'h01);
    cyc(3);
    d = n_done;
    rst_in = 1'b0;
    #1;
    chk("mid_rst_send", {7'b0, ser_send}, 8'h00);
    chk("mid_rst_busy", {7'b0, busy}, 8'h00);
    q0.delete();
    q1.delete();
    drive();
    cyc(3);
    rst_in = 1'b1;
    cyc(30);
    chk("mid_rst_done", 8'(n_done - d), 8'd0);
    chk("mid_rst_idle", {7'b0, busy}, 8'h00);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
